id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register and EX-stage operand front end of the RV32 core. It registers decoded instruction fields, resolves data hazards by forwarding from EX/MEM and MEM/WB, and selects the two ALU operands and the ALU operation code. It also detects load-use hazards and inserts bubbles. Its outputs drive the ALU inputs `Operand1`, `Operand2` and `AluType` directly.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `NOP_ALU`, 4'b0000: ALU code loaded on reset or bubble. It must equal the `ADD` code in Parameters.v.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: synchronous reset, active low. One clock; reset is synchronous and active-low.
- `id_valid`, in, 1: ID holds a real instruction.
- `id_pc`, in, 32: PC of the ID instruction.
- `id_rs1_data`, `id_rs2_data`, in, 32 each: register-file read data.
- `id_imm`, in, 32: sign-extended immediate.
- `id_rs1`, `id_rs2`, `id_rd`, in, 5 each: register indices.
- `id_alu_type`, in, 4: ALU operation (Parameters.v encoding).
- `id_op1_sel`, in, 2: operand 1 source. 00 = rs1, 01 = PC, 10 = zero, 11 = zero.
- `id_op2_sel`, in, 1: operand 2 source. 0 = rs2, 1 = imm.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, in, 1 each: control bits.
- `stall_i`, in, 1: downstream stall; hold the ID/EX contents.
- `flush_i`, in, 1: branch/trap flush; the ID/EX register becomes a bubble.
- `exmem_reg_write`, in, 1; `exmem_rd`, in, 5; `exmem_result`, in, 32: EX/MEM writeback candidate.
- `memwb_reg_write`, in, 1; `memwb_rd`, in, 5; `memwb_result`, in, 32: MEM/WB writeback (same cycle as the register-file write).
- `ex_valid`, out, 1: EX holds a real instruction.
- `Operand1`, `Operand2`, out, 32 each: ALU operands.
- `AluType`, out, 4: ALU operation.
- `ex_rd`, out, 5; `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, out, 1 each: control bits forwarded to EX/MEM. All three write/read bits are gated by `ex_valid`.
- `ex_store_data`, out, 32: forwarded rs2 value, used by stores.
- `load_use_stall`, out, 1: upstream must hold IF/ID this cycle.

## Operation
- Register update priority on each rising edge, highest first:
  1. `!rst_n`: clear.
  2. `flush_i`: load bubble.
  3. `stall_i`: hold.
  4. `load_use_stall`: load bubble.
  5. Otherwise: capture the ID fields.
- Clear and bubble both set: `ex_valid`=0, all control bits 0, `ex_rd`=0, `AluType`=`NOP_ALU`, data fields 0.
- Capture write-through: if `memwb_reg_write` is set, `memwb_rd`≠0 and `memwb_rd`==`id_rs1`, the stored rs1 value is `memwb_result`, not `id_rs1_data`. The same rule applies to rs2.
- Forwarding is combinational on the registered rs1 and rs2 indices:
  - EX/MEM match (write set, rd≠0, rd==rs) takes priority over a MEM/WB match.
  - With no match, use the registered data.
  - x0 is never forwarded.
- Operand selection:
  - `Operand1` = forwarded rs1, `ex_pc`, or 0, per `op1_sel`.
  - `Operand2` = forwarded rs2 or `ex_imm`, per `op2_sel`.
  - `ex_store_data` = forwarded rs2, always.
- `load_use_stall` = `id_valid` & `ex_valid` & `ex_mem_read` & (`ex_rd`≠0) & (`ex_rd`==`id_rs1` | `ex_rd`==`id_rs2`).
  - The comparison is conservative: it ignores the operand-select fields.
  - It is combinational and never asserted while `ex_valid`=0.
- `flush_i` together with `load_use_stall`: bubble. The upstream flush also discards the ID instruction.
- `stall_i` together with `load_use_stall`: hold. The hazard re-evaluates the next cycle.

## Timing
- Latency: an ID instruction captured at edge N has its operands valid at the ALU during cycle N→N+1.
- Forwarding and operand-select paths are combinational; there is no extra cycle.
- `load_use_stall` is valid in the same cycle as the ID inputs. It forces exactly one bubble per load-use pair unless `stall_i` extends it.
- Reset:
  - Takes effect at the first edge with `rst_n`=0 and dominates `flush_i` and `stall_i`.
  - Reset asserted mid-stall discards the held instruction.
- Outputs after reset: `ex_valid`=0, `Operand1`=0, `Operand2`=0, `AluType`=`NOP_ALU`, `ex_rd`=0, all control bits 0, `ex_store_data`=0, `load_use_stall`=0.

## Test plan
- Basic capture:
  - Stimulus: `id_rs1_data`=5, `id_imm`=7, op1_sel=00, op2_sel=1, ALU=ADD, no hazards.
  - Required: next cycle `Operand1`=5, `Operand2`=7, `ex_valid`=1.
- Forward priority:
  - Stimulus: registered rs1=x3, with EX/MEM writing x3=0xAAAA and MEM/WB writing x3=0xBBBB simultaneously.
  - Required: `Operand1`=0xAAAA. With `exmem_reg_write` dropped: 0xBBBB. With rd=x0 in both: registered data.
- Load-use:
  - Stimulus: EX holds a load into x5; ID reads x5 as rs2.
  - Required: `load_use_stall`=1 for one cycle. The next cycle has `ex_valid`=0 and `AluType`=`NOP_ALU`. On re-issue, the MEM/WB write-through captures the loaded value.
- Stall vs flush:
  - Stimulus: hold 3 cycles with `stall_i`=1 and changing ID inputs.
  - Required: outputs unchanged. Asserting `flush_i` together with `stall_i` gives a bubble on the next edge.
- Reset mid-operation:
  - Stimulus: drive `rst_n`=0 for one edge while `ex_valid`=1 and `stall_i`=1.
  - Required: all outputs at their reset values after that edge.

Source files
------------

// File: rtl/id_ex_if.sv
// id_ex_if: bundle between the decode stage, the writeback/forwarding sources,
// and the ID/EX register with its EX operand front end.
//   master : decode/hazard-unit side, drives ID fields, stall/flush and
//            the EX/MEM and MEM/WB writeback candidates.
//   slave  : id_ex_stage, returns ALU operands, EX control bits and
//            the load-use stall request.
interface id_ex_if #(
  parameter int XLEN = 32
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic [3:0]      id_alu_type;
  logic [1:0]      id_op1_sel;
  logic            id_op2_sel;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            stall_i;
  logic            flush_i;
  logic            exmem_reg_write;
  logic [4:0]      exmem_rd;
  logic [XLEN-1:0] exmem_result;
  logic            memwb_reg_write;
  logic [4:0]      memwb_rd;
  logic [XLEN-1:0] memwb_result;

  logic            ex_valid;
  logic [XLEN-1:0] Operand1;
  logic [XLEN-1:0] Operand2;
  logic [3:0]      AluType;
  logic [4:0]      ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic [XLEN-1:0] ex_store_data;
  logic            load_use_stall;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_alu_type, id_op1_sel, id_op2_sel,
           id_reg_write, id_mem_read, id_mem_write, stall_i, flush_i,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  ex_valid, Operand1, Operand2, AluType, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_store_data, load_use_stall
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_alu_type, id_op1_sel, id_op2_sel,
           id_reg_write, id_mem_read, id_mem_write, stall_i, flush_i,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output ex_valid, Operand1, Operand2, AluType, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_store_data, load_use_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register plus EX operand front end of the RV32
// core. Registers decoded fields, forwards from EX/MEM and MEM/WB, selects
// the ALU operands/operation, and inserts a bubble on a load-use hazard.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous reset, active low
//   bus   : id_ex_if.slave (ID fields, stall/flush, writeback candidates in;
//           Operand1/Operand2/AluType, EX control, store data,
//           load_use_stall out)
module id_ex_stage #(
  parameter int         XLEN    = 32,
  parameter logic [3:0] NOP_ALU = 4'b0000
) (
  input logic    clk,
  input logic    rst_n,
  id_ex_if.slave bus
);

  logic            vld_p1;
  logic [XLEN-1:0] pc_p1;
  logic [XLEN-1:0] rs1_data_p1;
  logic [XLEN-1:0] rs2_data_p1;
  logic [XLEN-1:0] imm_p1;
  logic [4:0]      rs1_p1;
  logic [4:0]      rs2_p1;
  logic [4:0]      rd_p1;
  logic [3:0]      alu_p1;
  logic [1:0]      op1_sel_p1;
  logic            op2_sel_p1;
  logic            reg_write_p1;
  logic            mem_read_p1;
  logic            mem_write_p1;

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic            lus;

  // MEM/WB bypass: the register file is written in the same cycle it is
  // read, so a matching writeback overrides the read data.
  function automatic logic [XLEN-1:0] wb_bypass(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf_data,
    input logic            wb_we,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_data
  );
    return (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) ? wb_data : rf_data;
  endfunction

  // EX/MEM is younger than MEM/WB and therefore wins.
  function automatic logic [XLEN-1:0] fwd(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] reg_data,
    input logic            ex_we,
    input logic [4:0]      ex_rdi,
    input logic [XLEN-1:0] ex_data,
    input logic            wb_we,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_data
  );
    if (ex_we && (ex_rdi != 5'd0) && (ex_rdi == rs)) return ex_data;
    return wb_bypass(rs, reg_data, wb_we, wb_rd, wb_data);
  endfunction

  // Conservative: any rs index match counts, regardless of operand select.
  assign lus = bus.id_valid & vld_p1 & mem_read_p1 & (rd_p1 != 5'd0) &
               ((rd_p1 == bus.id_rs1) | (rd_p1 == bus.id_rs2));

  // ---- ID -> EX register boundary (p1) ----
  // A stall holds even when a load-use hazard is pending; flush and reset
  // always win.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush_i || (!bus.stall_i && lus)) begin
      vld_p1       <= 1'b0;
      pc_p1        <= '0;
      rs1_data_p1  <= '0;
      rs2_data_p1  <= '0;
      imm_p1       <= '0;
      rs1_p1       <= 5'd0;
      rs2_p1       <= 5'd0;
      rd_p1        <= 5'd0;
      alu_p1       <= NOP_ALU;
      op1_sel_p1   <= 2'b00;
      op2_sel_p1   <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
    end else if (!bus.stall_i) begin
      vld_p1       <= bus.id_valid;
      pc_p1        <= bus.id_pc;
      rs1_data_p1  <= wb_bypass(bus.id_rs1, bus.id_rs1_data, bus.memwb_reg_write,
                                bus.memwb_rd, bus.memwb_result);
      rs2_data_p1  <= wb_bypass(bus.id_rs2, bus.id_rs2_data, bus.memwb_reg_write,
                                bus.memwb_rd, bus.memwb_result);
      imm_p1       <= bus.id_imm;
      rs1_p1       <= bus.id_rs1;
      rs2_p1       <= bus.id_rs2;
      rd_p1        <= bus.id_rd;
      alu_p1       <= bus.id_alu_type;
      op1_sel_p1   <= bus.id_op1_sel;
      op2_sel_p1   <= bus.id_op2_sel;
      reg_write_p1 <= bus.id_reg_write;
      mem_read_p1  <= bus.id_mem_read;
      mem_write_p1 <= bus.id_mem_write;
    end
  end

  // ---- EX operand front end (combinational off p1) ----
  always_comb begin
    rs1_fwd = fwd(rs1_p1, rs1_data_p1, bus.exmem_reg_write, bus.exmem_rd,
                  bus.exmem_result, bus.memwb_reg_write, bus.memwb_rd,
                  bus.memwb_result);
    rs2_fwd = fwd(rs2_p1, rs2_data_p1, bus.exmem_reg_write, bus.exmem_rd,
                  bus.exmem_result, bus.memwb_reg_write, bus.memwb_rd,
                  bus.memwb_result);
    bus.Operand1 = '0;
    case (op1_sel_p1)
      2'b00:   bus.Operand1 = rs1_fwd;
      2'b01:   bus.Operand1 = pc_p1;
      default: bus.Operand1 = '0;
    endcase
    bus.Operand2 = op2_sel_p1 ? imm_p1 : rs2_fwd;
  end

  assign bus.ex_store_data  = rs2_fwd;
  assign bus.AluType        = alu_p1;
  assign bus.ex_valid       = vld_p1;
  assign bus.ex_rd          = rd_p1;
  assign bus.ex_reg_write   = vld_p1 & reg_write_p1;
  assign bus.ex_mem_read    = vld_p1 & mem_read_p1;
  assign bus.ex_mem_write   = vld_p1 & mem_write_p1;
  assign bus.load_use_stall = lus;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scoreboard bench for id_ex_stage. Stimulus pushes
// the hand-computed expected outputs for each cycle; a negedge monitor pops
// and compares them against the DUT.
module tb_id_ex_stage;
  localparam logic [3:0] NOP = 4'b0000;

  logic clk;
  logic rst_n;

  id_ex_if #(.XLEN(32)) bus ();

  id_ex_stage #(.XLEN(32), .NOP_ALU(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] o1;
    logic [31:0] o2;
    logic [31:0] sd;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        lus;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100000");
    $fatal(1);
  end

  // Monitor: compares whatever expectation is pending at each negedge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (bus.ex_valid !== e.v || bus.Operand1 !== e.o1 || bus.Operand2 !== e.o2 ||
          bus.ex_store_data !== e.sd || bus.AluType !== e.alu || bus.ex_rd !== e.rd ||
          bus.ex_reg_write !== e.rw || bus.ex_mem_read !== e.mr ||
          bus.ex_mem_write !== e.mw || bus.load_use_stall !== e.lus) begin
        errors++;
        $display("FAIL %s: got v=%0b o1=%h o2=%h sd=%h alu=%h rd=%0d rw=%0b mr=%0b mw=%0b lus=%0b, required v=%0b o1=%h o2=%h sd=%h alu=%h rd=%0d rw=%0b mr=%0b mw=%0b lus=%0b",
                 e.name, bus.ex_valid, bus.Operand1, bus.Operand2, bus.ex_store_data,
                 bus.AluType, bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read,
                 bus.ex_mem_write, bus.load_use_stall,
                 e.v, e.o1, e.o2, e.sd, e.alu, e.rd, e.rw, e.mr, e.mw, e.lus);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] r1d,
                        input logic [31:0] r2d, input logic [31:0] imm,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic [3:0] alu, input logic [1:0] s1, input logic s2,
                        input logic rw, input logic mr, input logic mw);
    bus.id_valid     = v;
    bus.id_pc        = pc;
    bus.id_rs1_data  = r1d;
    bus.id_rs2_data  = r2d;
    bus.id_imm       = imm;
    bus.id_rs1       = r1;
    bus.id_rs2       = r2;
    bus.id_rd        = rd;
    bus.id_alu_type  = alu;
    bus.id_op1_sel   = s1;
    bus.id_op2_sel   = s2;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.id_mem_write = mw;
  endtask

  task automatic fwd_in(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                        input logic ww, input logic [4:0] wrd, input logic [31:0] wres);
    bus.exmem_reg_write = ew;
    bus.exmem_rd        = erd;
    bus.exmem_result    = eres;
    bus.memwb_reg_write = ww;
    bus.memwb_rd        = wrd;
    bus.memwb_result    = wres;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [31:0] o1,
                            input logic [31:0] o2, input logic [31:0] sd,
                            input logic [3:0] alu, input logic [4:0] rd,
                            input logic rw, input logic mr, input logic mw,
                            input logic lus);
    exp_t e;
    e.name = name; e.v = v; e.o1 = o1; e.o2 = o2; e.sd = sd; e.alu = alu;
    e.rd = rd; e.rw = rw; e.mr = mr; e.mw = mw; e.lus = lus;
    q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 2'b00, 0, 0, 0, 0);
    fwd_in(0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;

    // Basic capture: rs1 + imm
    set_id(1, 32'h100, 5, 9, 7, 1, 2, 4, 4'h0, 2'b00, 1, 1, 0, 0);
    expect_out("reset", 0, 0, 0, 0, NOP, 0, 0, 0, 0, 0); tick();
    set_id(1, 32'h200, 32'h1111, 32'h2222, 32'h33, 3, 6, 7, 4'h7, 2'b00, 0, 1, 0, 0);
    expect_out("capture", 1, 5, 7, 9, 4'h0, 4, 1, 0, 0, 0); tick();

    // Forward priority on registered rs1 = x3, held by stall
    bus.stall_i = 1'b1;
    fwd_in(1, 3, 32'hAAAA, 1, 3, 32'hBBBB);
    expect_out("fwd_exmem", 1, 32'hAAAA, 32'h2222, 32'h2222, 4'h7, 7, 1, 0, 0, 0); tick();
    fwd_in(0, 3, 32'hAAAA, 1, 3, 32'hBBBB);
    expect_out("fwd_memwb", 1, 32'hBBBB, 32'h2222, 32'h2222, 4'h7, 7, 1, 0, 0, 0); tick();
    fwd_in(1, 0, 32'hAAAA, 1, 0, 32'hBBBB);
    expect_out("fwd_x0", 1, 32'h1111, 32'h2222, 32'h2222, 4'h7, 7, 1, 0, 0, 0); tick();
    bus.stall_i = 1'b0;
    fwd_in(1, 9, 32'h99, 0, 0, 0);
    set_id(1, 32'h300, 32'h10, 32'h20, 32'h40, 8, 9, 10, 4'h2, 2'b01, 0, 1, 0, 0);
    expect_out("fwd_none", 1, 32'h1111, 32'h2222, 32'h2222, 4'h7, 7, 1, 0, 0, 0); tick();

    // PC operand with rs2 forwarded from EX/MEM; next capture gets write-through
    fwd_in(1, 9, 32'h99, 1, 12, 32'hCC);
    set_id(1, 32'h400, 32'h55, 32'h66, 32'h77, 11, 12, 13, 4'h3, 2'b11, 1, 0, 0, 1);
    expect_out("op1_pc", 1, 32'h300, 32'h99, 32'h99, 4'h2, 10, 1, 0, 0, 0); tick();
    fwd_in(0, 0, 0, 0, 0, 0);
    set_id(1, 32'h500, 32'h1000, 0, 8, 14, 0, 5, 4'h0, 2'b00, 1, 1, 1, 0);
    expect_out("op1_zero_store", 1, 0, 32'h77, 32'hCC, 4'h3, 13, 0, 0, 1, 0); tick();

    // Load-use: EX loads x5, ID reads x5 as rs2
    set_id(1, 32'h504, 1, 32'hDEAD, 0, 1, 5, 6, 4'h0, 2'b00, 0, 1, 0, 0);
    expect_out("load_use", 1, 32'h1000, 8, 0, 4'h0, 5, 1, 1, 0, 1); tick();
    fwd_in(0, 0, 0, 1, 5, 32'hFEED);
    expect_out("lu_bubble", 0, 0, 0, 0, NOP, 0, 0, 0, 0, 0); tick();
    fwd_in(0, 0, 0, 0, 0, 0);
    set_id(1, 32'h600, 32'hA1, 32'hB2, 32'hC3, 15, 16, 17, 4'h5, 2'b00, 0, 1, 0, 0);
    expect_out("reissue_wt", 1, 1, 32'hFEED, 32'hFEED, 4'h0, 6, 1, 0, 0, 0); tick();

    // Stall with changing ID inputs, then flush during stall
    bus.stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_id(1, 32'h700 + i, 7 + i, 8 + i, 9 + i, 18, 19, 20, 4'h6, 2'b01, 1, 0, 1, 0);
      if (i == 3) bus.flush_i = 1'b1;
      expect_out($sformatf("stall_hold%0d", i), 1, 32'hA1, 32'hB2, 32'hB2, 4'h5, 17, 1, 0, 0, 0);
      tick();
    end
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    set_id(1, 32'h600, 32'hA1, 32'hB2, 32'hC3, 15, 16, 17, 4'h5, 2'b00, 0, 1, 0, 0);
    expect_out("flush_bubble", 0, 0, 0, 0, NOP, 0, 0, 0, 0, 0); tick();

    // Reset while stalled with a valid instruction
    bus.stall_i = 1'b1;
    rst_n = 1'b0;
    expect_out("pre_reset", 1, 32'hA1, 32'hB2, 32'hB2, 4'h5, 17, 1, 0, 0, 0); tick();
    rst_n = 1'b1;
    bus.stall_i = 1'b0;
    set_id(1, 32'h500, 32'h1000, 0, 8, 14, 0, 5, 4'h0, 2'b00, 1, 1, 1, 0);
    expect_out("reset_mid", 0, 0, 0, 0, NOP, 0, 0, 0, 0, 0); tick();

    // Load-use under stall holds; flush then bubbles
    set_id(1, 32'h504, 1, 32'hDEAD, 0, 1, 5, 6, 4'h0, 2'b00, 0, 1, 0, 0);
    bus.stall_i = 1'b1;
    expect_out("lus_stall", 1, 32'h1000, 8, 0, 4'h0, 5, 1, 1, 0, 1); tick();
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b1;
    expect_out("lus_held", 1, 32'h1000, 8, 0, 4'h0, 5, 1, 1, 0, 1); tick();
    bus.flush_i = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 2'b00, 0, 0, 0, 0);
    expect_out("lus_flush", 0, 0, 0, 0, NOP, 0, 0, 0, 0, 0); tick();

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
